// File: rtl/vga_frame_receiver_if.sv
// vga_frame_receiver_if: VGA input bundle plus captured-pixel outputs.
// The receiver takes the slave side; the video source/sink takes master.
interface vga_frame_receiver_if;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic [9:0]  rx_x;
    logic [9:0]  rx_y;
    logic [2:0]  rx_rgb;
    logic        pixel_valid;
    logic        locked;
    logic        frame_done;
    logic        sync_error;
    logic [18:0] frame_lit_count;

    modport master (
        output hsync, vsync, rgb,
        input  rx_x, rx_y, rx_rgb, pixel_valid, locked,
        input  frame_done, sync_error, frame_lit_count
    );

    modport slave (
        input  hsync, vsync, rgb,
        output rx_x, rx_y, rx_rgb, pixel_valid, locked,
        output frame_done, sync_error, frame_lit_count
    );
endinterface

// File: rtl/vga_frame_receiver.sv
// vga_frame_receiver: recovers VGA timing, locks onto clean frames, captures pixels.
// Option: define VGA_RX_PIXEL_COUNT_EN for the per-frame lit-pixel counter.
module vga_frame_receiver #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input logic clk,
    input logic reset,
    vga_frame_receiver_if.slave vif
);
    localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BACK + H_VISIBLE + H_FRONT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BACK + V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0] H_PULSE = 10'(H_SYNC);
    localparam logic [9:0] X_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] X_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] Y_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] Y_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [9:0] X_LAST  = 10'(H_VISIBLE - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_VISIBLE - 1);
    localparam logic [9:0] CNT_MAX = 10'h3ff;

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic       hs_r, vs_r, hs_d, vs_d, vs_armed;
    logic [2:0] rgb_r;
    logic [9:0] hcnt, vline, hcnt_nxt, vline_nxt, x_nxt, y_nxt;
    logic [1:0] state, state_nxt;
    logic       line_start, hs_rise, vs_fall, frame_start, hsat, viol;
    logic       pv_nxt, err_nxt, fd_nxt;
    logic [9:0] px_x, px_y;
    logic [2:0] px_rgb;
    logic       px_valid, fd_q, err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
            rgb_r <= '0;
        end else begin
            hs_r  <= vif.hsync;
            vs_r  <= vif.vsync;
            rgb_r <= vif.rgb;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
        end
    end

    assign line_start  = hs_d & ~hs_r;
    assign hs_rise     = ~hs_d & hs_r;
    assign vs_fall     = vs_d & ~vs_r;
    // vsync may fall a little before the hsync edge that opens the frame
    assign frame_start = line_start & ~vs_r & (vs_fall | vs_armed);

    assign hcnt_nxt  = line_start ? 10'd0 :
                       (hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1;
    assign vline_nxt = frame_start ? 10'd0 :
                       line_start  ? vline + 10'd1 : vline;
    assign hsat      = (hcnt_nxt == CNT_MAX) & (hcnt != CNT_MAX);

    assign viol = (line_start & (hcnt != H_LAST))
                | (hs_rise & (hcnt_nxt != H_PULSE))
                | (frame_start & (vline != V_LAST))
                | hsat;

    assign x_nxt  = hcnt_nxt - X_START;
    assign y_nxt  = vline_nxt - Y_START;
    assign pv_nxt = (state == LOCKED) & ~viol
                  & (hcnt_nxt >= X_START) & (hcnt_nxt < X_END)
                  & (vline_nxt >= Y_START) & (vline_nxt < Y_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt     <= '0;
            vline    <= '0;
            vs_armed <= 1'b0;
        end else begin
            hcnt     <= hcnt_nxt;
            vline    <= vline_nxt;
            vs_armed <= line_start ? 1'b0 :
                        vs_fall    ? 1'b1 :
                        vs_r       ? 1'b0 : vs_armed;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                if (frame_start) state_nxt = ACQUIRE;
            end
            ACQUIRE: begin
                if (viol) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end else if (frame_start) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    assign fd_nxt = px_valid & (px_x == X_LAST) & (px_y == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEARCH;
            px_x     <= '0;
            px_y     <= '0;
            px_rgb   <= '0;
            px_valid <= 1'b0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            px_x     <= pv_nxt ? x_nxt : 10'd0;
            px_y     <= pv_nxt ? y_nxt : 10'd0;
            px_rgb   <= pv_nxt ? rgb_r : 3'd0;
            px_valid <= pv_nxt;
            fd_q     <= fd_nxt;
            err_q    <= err_nxt;
        end
    end

    assign vif.rx_x        = px_x;
    assign vif.rx_y        = px_y;
    assign vif.rx_rgb      = px_rgb;
    assign vif.pixel_valid = px_valid;
    assign vif.locked      = (state == LOCKED);
    assign vif.frame_done  = fd_q;
    assign vif.sync_error  = err_q;

`ifdef VGA_RX_PIXEL_COUNT_EN
    logic [18:0] lit_acc, lit_total, lit_q;

    assign lit_total = lit_acc + {18'd0, px_valid & (px_rgb != 3'd0)};

    // a partial count from a lost lock must not leak into the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lit_acc <= '0;
            lit_q   <= '0;
        end else if (fd_nxt) begin
            lit_q   <= lit_total;
            lit_acc <= '0;
        end else if (state != LOCKED) begin
            lit_acc <= '0;
        end else begin
            lit_acc <= lit_total;
        end
    end

    assign vif.frame_lit_count = lit_q;
`else
    assign vif.frame_lit_count = '0;
`endif
endmodule

// File: tb/tb_vga_frame_receiver.sv
// tb_vga_frame_receiver: directed frames on a reduced raster, scoreboarded
// against per-pixel expectations derived from the generated raster position.
module tb_vga_frame_receiver;
    localparam int HV = 32;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 141;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VT = VV + VF + VS + VB;
    localparam int NONE = 10000;

    typedef struct packed {
        logic        lk;
        logic        se;
        logic        fd;
        logic        v;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  c;
        logic [18:0] flc;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    vga_frame_receiver_if vif();

    vga_frame_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vif(vif)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   se_cnt = 0;
    int   fd_cnt = 0;
    int   acc_m = 0;
    int   flc_m = 0;
    int   pat = 0;
    logic exp_lk = 1'b0;
    logic fd_pend = 1'b0;
    logic arm_lit = 1'b0;
    logic got_lit = 1'b0;
    logic [9:0] lit_x = '0;
    logic [9:0] lit_y = '0;
    logic [2:0] lit_c = '0;
    ent_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        obs_t o;
        ent_t e;
        if (vif.sync_error) se_cnt++;
        if (vif.frame_done) fd_cnt++;
        if (arm_lit && !got_lit && vif.pixel_valid && vif.rx_rgb != 3'd0) begin
            got_lit = 1'b1;
            lit_x = vif.rx_x;
            lit_y = vif.rx_y;
            lit_c = vif.rx_rgb;
        end
        if (sb.size() > 0 && sb[0].cyc + 2 == cyc) begin
            e = sb.pop_front();
            o.lk  = vif.locked;
            o.se  = vif.sync_error;
            o.fd  = vif.frame_done;
            o.v   = vif.pixel_valid;
            o.x   = vif.rx_x;
            o.y   = vif.rx_y;
            o.c   = vif.rx_rgb;
            o.flc = vif.frame_lit_count;
            n_tests++;
            assert (o === e.o) else begin
                n_fail++;
                $error("FAIL pix cyc=%0d obs=%h exp=%h", e.cyc, o, e.o);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(vif.locked), 0);
        chk({tag, "_valid"}, 32'(vif.pixel_valid), 0);
        chk({tag, "_x"}, 32'(vif.rx_x), 0);
        chk({tag, "_y"}, 32'(vif.rx_y), 0);
        chk({tag, "_rgb"}, 32'(vif.rx_rgb), 0);
        chk({tag, "_fd"}, 32'(vif.frame_done), 0);
        chk({tag, "_se"}, 32'(vif.sync_error), 0);
        chk({tag, "_flc"}, 32'(vif.frame_lit_count), 0);
    endtask

    task automatic pix(input logic h, input logic v, input logic [2:0] c,
                       input int x, input int y, input logic se);
        ent_t e;
        logic vis;
        @(negedge clk);
        vif.hsync = h;
        vif.vsync = v;
        vif.rgb   = c;
        vis = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
        if (se) exp_lk = 1'b0;
        if (fd_pend) begin
            flc_m = acc_m;
            acc_m = 0;
        end
        e.cyc  = cyc;
        e.o.lk = exp_lk;
        e.o.se = se;
        e.o.fd = fd_pend;
        e.o.v  = exp_lk && vis;
        e.o.x  = e.o.v ? 10'(x) : 10'd0;
        e.o.y  = e.o.v ? 10'(y) : 10'd0;
        e.o.c  = e.o.v ? c : 3'd0;
`ifdef VGA_RX_PIXEL_COUNT_EN
        e.o.flc = 19'(flc_m);
`else
        e.o.flc = '0;
`endif
        sb.push_back(e);
        fd_pend = e.o.v && (x == HV - 1) && (y == VV - 1);
        if (!exp_lk) acc_m = 0;
        else if (e.o.v && c != 3'd0) acc_m++;
    endtask

    task automatic line(input int ln, input int len, input logic se_first);
        for (int p = 0; p < len; p++) begin
            int x;
            int y;
            logic [2:0] c;
            x = p - HS - HB;
            y = ln - VS - VB;
            if (pat == 1)
                c = (x >= 20 && x <= 30 && y >= 100 && y <= 140) ? 3'b111 : 3'b000;
            else
                c = 3'($urandom_range(0, 7));
            pix(p >= HS, ln >= VS, c, x, y, se_first && p == 0);
        end
    endtask

    task automatic hold(input int ln);
        for (int k = 0; k < 1100; k++)
            pix(1'b1, ln >= VS, 3'($urandom_range(0, 7)), -1, -1, (HT + k) == 1023);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        sb.delete();
        exp_lk  = 1'b0;
        fd_pend = 1'b0;
        acc_m   = 0;
        flc_m   = 0;
    endtask

    task automatic frame(input logic lk_first, input int pat_sel,
                         input int short_ln, input int lost_ln, input int rst_ln);
        pat = pat_sel;
        if (lk_first) exp_lk = 1'b1;
        for (int ln = 0; ln < VT; ln++) begin
            if (ln == rst_ln) reset_mid();
            line(ln, (ln == short_ln) ? HT - 1 : HT, ln == short_ln + 1);
            if (ln == rst_ln) reset = 1'b0;
            if (ln == lost_ln) hold(ln);
        end
    endtask

    initial begin
        int lit_want;
`ifdef VGA_RX_PIXEL_COUNT_EN
        lit_want = 451;
`else
        lit_want = 0;
`endif
        vif.hsync = 1'b1;
        vif.vsync = 1'b1;
        vif.rgb   = 3'd0;
        reset     = 1'b1;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        frame(1'b0, 0, NONE, NONE, NONE);
        chk("acq_locked", 32'(vif.locked), 0);
        frame(1'b1, 0, NONE, NONE, NONE);
        frame(1'b0, 0, NONE, NONE, NONE);
        chk("clean_locked", 32'(vif.locked), 1);
        chk("clean_fd", 32'(fd_cnt), 2);
        chk("clean_se", 32'(se_cnt), 0);

        arm_lit = 1'b1;
        frame(1'b0, 1, NONE, NONE, NONE);
        arm_lit = 1'b0;
        chk("box_x", 32'(lit_x), 20);
        chk("box_y", 32'(lit_y), 100);
        chk("box_rgb", 32'(lit_c), 7);
        chk("box_flc", 32'(vif.frame_lit_count), 32'(lit_want));
        chk("box_fd", 32'(fd_cnt), 3);

        frame(1'b0, 0, 50, NONE, NONE);
        chk("short_se", 32'(se_cnt), 1);
        chk("short_locked", 32'(vif.locked), 0);
        frame(1'b0, 0, NONE, NONE, NONE);
        chk("short_acq", 32'(vif.locked), 0);
        frame(1'b1, 1, NONE, NONE, NONE);
        chk("relock", 32'(vif.locked), 1);
        chk("relock_flc", 32'(vif.frame_lit_count), 32'(lit_want));
        chk("relock_fd", 32'(fd_cnt), 4);

        frame(1'b0, 0, NONE, 60, NONE);
        chk("lost_se", 32'(se_cnt), 2);
        chk("lost_locked", 32'(vif.locked), 0);
        frame(1'b0, 0, NONE, NONE, NONE);
        frame(1'b1, 0, NONE, NONE, 100);
        chk("rst_locked", 32'(vif.locked), 0);
        frame(1'b0, 0, NONE, NONE, NONE);
        chk("rst_acq", 32'(vif.locked), 0);
        frame(1'b1, 0, NONE, NONE, NONE);
        chk("rst_relock", 32'(vif.locked), 1);
        chk("final_se", 32'(se_cnt), 2);
        chk("final_fd", 32'(fd_cnt), 5);

        for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 3'd0, -1, -1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
